// File: rtl/pmem_dump.sv
// PMem block dump: streams a header byte, two bytes per instruction and
// an 8-bit checksum over a valid/ready byte interface.
module pmem_dump #(
  parameter int ADDR_W = 8,
  parameter int INST_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              mem_E,
  output logic [ADDR_W-1:0] mem_Addr,
  input  logic [INST_W-1:0] mem_Inst,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HEADER,
    S_READ,
    S_CAPTURE,
    S_SEND_HI,
    S_SEND_LO,
    S_SEND_SUM
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [INST_W-1:0] r_inst;
  logic [7:0]        r_sum;
  logic              r_done;
  logic              w_xfer;
  logic [15:0]       w_inst16;

  assign w_xfer   = tx_valid && tx_ready;
  assign w_inst16 = 16'(r_inst);
  assign done     = r_done;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:     if (start) w_next = S_HEADER;
      S_HEADER:
        if (w_xfer)
          w_next = (r_cnt == '0) ? S_SEND_SUM : S_READ;
      S_READ:     w_next = S_CAPTURE;
      S_CAPTURE:  w_next = S_SEND_HI;
      S_SEND_HI:  if (w_xfer) w_next = S_SEND_LO;
      S_SEND_LO:
        if (w_xfer)
          w_next = (r_rem == ADDR_W'(1)) ? S_SEND_SUM : S_READ;
      S_SEND_SUM: if (w_xfer) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_E    = 1'b0;
    mem_Addr = r_mem_addr;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    busy     = (r_state != S_IDLE);
    unique case (r_state)
      S_HEADER: begin
        tx_valid = 1'b1;
        tx_data  = 8'(r_cnt);
      end
      S_READ: begin
        mem_E    = 1'b1;
        mem_Addr = r_addr;
      end
      S_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = w_inst16[15:8];
      end
      S_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = w_inst16[7:0];
      end
      S_SEND_SUM: begin
        tx_valid = 1'b1;
        tx_data  = r_sum;
      end
      default: ;
    endcase
  end

  // Checksum accumulates every byte sent before the checksum itself.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr     <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
      r_mem_addr <= '0;
      r_inst     <= '0;
      r_sum      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE:
          if (start) begin
            r_addr <= base_addr;
            r_rem  <= count;
            r_cnt  <= count;
            r_sum  <= '0;
          end
        S_HEADER:
          if (w_xfer) r_sum <= r_sum + tx_data;
        S_READ:    r_mem_addr <= r_addr;
        S_CAPTURE: r_inst <= mem_Inst;
        S_SEND_HI:
          if (w_xfer) r_sum <= r_sum + tx_data;
        S_SEND_LO:
          if (w_xfer) begin
            r_sum <= r_sum + tx_data;
            r_rem <= r_rem - ADDR_W'(1);
            if (r_rem != ADDR_W'(1))
              r_addr <= r_addr + ADDR_W'(1);
          end
        S_SEND_SUM:
          if (w_xfer) r_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_dump.sv
// Directed bench for pmem_dump: registered PMem model, byte monitor
// and hand-computed expected streams.
module tb_pmem_dump;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic [7:0]  count;
  logic        mem_E;
  logic [7:0]  mem_Addr;
  logic [11:0] mem_Inst = '0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  logic [11:0] pmem [256];
  logic [7:0]  q[$];
  logic [7:0]  eq[$];
  logic [7:0]  addrs[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_done = 0;
  int          n_memE = 0;

  pmem_dump dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_E     (mem_E),
    .mem_Addr  (mem_Addr),
    .mem_Inst  (mem_Inst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_E) mem_Inst <= pmem[mem_Addr];

  always @(negedge clk) begin
    if (tx_valid && tx_ready) q.push_back(tx_data);
    if (done) n_done++;
    if (mem_E) begin
      n_memE++;
      addrs.push_back(mem_Addr);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_q(input string tag);
    chk({tag, " len"}, q.size(), eq.size());
    foreach (eq[i])
      chk($sformatf("%s b%0d", tag, i),
          (i < q.size()) ? {24'h0, q[i]} : 32'hdead, {24'h0, eq[i]});
  endtask

  task automatic start_dump(input logic [7:0] b, input logic [7:0] c);
    q.delete();
    addrs.delete();
    n_memE = 0;
    @(posedge clk); #1;
    base_addr = b;
    count     = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    int d0;
    d0 = n_done;
    k  = 0;
    while (n_done == d0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk({tag, " done"}, n_done - d0, 1);
    chk({tag, " busy"}, {31'h0, busy}, 0);
  endtask

  task automatic wait_byte(input string tag, input logic [7:0] b);
    int k;
    k = 0;
    while (!(tx_valid && tx_data == b) && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, " seen"}, {31'h0, tx_valid && tx_data == b}, 1);
  endtask

  initial begin
    int d0;
    foreach (pmem[i]) pmem[i] = '0;
    pmem[0]     = 12'hA5C;
    pmem[1]     = 12'h123;
    pmem[8'hFF] = 12'h0BC;
    rst       = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    tx_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst tx_valid", {31'h0, tx_valid}, 0);
    chk("rst tx_data",  {24'h0, tx_data}, 0);
    chk("rst busy",     {31'h0, busy}, 0);
    chk("rst mem_E",    {31'h0, mem_E}, 0);
    chk("rst mem_Addr", {24'h0, mem_Addr}, 0);
    chk("rst done",     {31'h0, done}, 0);
    rst = 1'b1;

    start_dump(8'h00, 8'h02);
    chk("s1 hdr valid", {31'h0, tx_valid}, 1);
    chk("s1 hdr busy",  {31'h0, busy}, 1);
    wait_done("s1");
    eq = '{8'h02, 8'h0A, 8'h5C, 8'h01, 8'h23, 8'h8C};
    check_q("s1");
    chk("s1 nmemE", n_memE, 2);

    start_dump(8'h00, 8'h00);
    wait_done("s2");
    eq = '{8'h00, 8'h00};
    check_q("s2");
    chk("s2 nmemE", n_memE, 0);

    start_dump(8'h00, 8'h02);
    wait_byte("s3", 8'h0A);
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("s3 stall valid", {31'h0, tx_valid}, 1);
      chk("s3 stall data",  {24'h0, tx_data}, 32'h0A);
      @(posedge clk);
    end
    #1;
    tx_ready = 1'b1;
    wait_done("s3");
    eq = '{8'h02, 8'h0A, 8'h5C, 8'h01, 8'h23, 8'h8C};
    check_q("s3");

    start_dump(8'hFF, 8'h02);
    wait_done("s4");
    chk("s4 naddr", addrs.size(), 2);
    if (addrs.size() == 2) begin
      chk("s4 addr0", {24'h0, addrs[0]}, 32'hFF);
      chk("s4 addr1", {24'h0, addrs[1]}, 32'h00);
    end
    eq = '{8'h02, 8'h00, 8'hBC, 8'h0A, 8'h5C, 8'h24};
    check_q("s4");

    d0 = n_done;
    start_dump(8'h00, 8'h02);
    wait_byte("s5", 8'h5C);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("s5 tx_valid", {31'h0, tx_valid}, 0);
    chk("s5 busy",     {31'h0, busy}, 0);
    chk("s5 mem_E",    {31'h0, mem_E}, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("s5 no done", n_done - d0, 0);
    start_dump(8'h00, 8'h02);
    wait_done("s5r");
    eq = '{8'h02, 8'h0A, 8'h5C, 8'h01, 8'h23, 8'h8C};
    check_q("s5r");

    start_dump(8'h00, 8'h02);
    wait_byte("s6", 8'h0A);
    base_addr = 8'h10;
    count     = 8'h05;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    wait_done("s6");
    eq = '{8'h02, 8'h0A, 8'h5C, 8'h01, 8'h23, 8'h8C};
    check_q("s6");
    chk("s6 nmemE", n_memE, 2);
    repeat (5) @(posedge clk);
    #1;
    chk("s6 idle busy", {31'h0, busy}, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
